pdm_deserializer: RTL and testbench



---
 rtl/pdm_deserializer_if.sv | 12 +
 rtl/pdm_deserializer.sv | 140 ++++++++++++++
 tb/tb_pdm_deserializer.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pdm_deserializer_if.sv
// Word output channel of pdm_deserializer: valid/ready handshake plus overrun pulse.
interface pdm_deserializer_if #(
  parameter int DW = 16
);
  logic [DW-1:0] data_o;
  logic          valid_o;
  logic          ready_i;
  logic          overrun_o;

  modport master (output data_o, output valid_o, output overrun_o, input ready_i);
  modport slave  (input data_o, input valid_o, input overrun_o, output ready_i);
endinterface

// File: rtl/pdm_deserializer.sv
// PDM mic clock generator and mono/stereo bit packer with a one-word output buffer.
// Define PDM_DENSITY_EN to emit per-channel ones counts (boxcar decimation) instead of raw bits.
module pdm_deserializer_chan #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             sample_i,
  input  logic             bit_i,
`ifdef PDM_DENSITY_EN
  input  logic             complete_i,
`endif
  output logic [WIDTH-1:0] field_o
);
`ifdef PDM_DENSITY_EN
  localparam int NW = $clog2(WIDTH + 1);

  logic [NW-1:0] ones_q, ones_d, ones_now;

  // field_o includes the bit sampled this cycle so the completing sample is counted
  always_comb begin
    ones_now = ones_q + NW'(sample_i && bit_i);
    ones_d   = complete_i ? '0 : ones_now;
  end

  assign field_o = WIDTH'(ones_now);

  always_ff @(posedge clock) begin
    if (reset || clr) ones_q <= '0;
    else              ones_q <= ones_d;
  end
`else
  logic [WIDTH-1:0] sh_q, sh_d;

  assign sh_d    = sample_i ? {sh_q[WIDTH-2:0], bit_i} : sh_q;
  assign field_o = sh_d;

  always_ff @(posedge clock) begin
    if (reset || clr) sh_q <= '0;
    else              sh_q <= sh_d;
  end
`endif
endmodule

module pdm_deserializer #(
  parameter int CLK_DIV  = 50,
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               data_in,
  output logic               pdm_clk_o,
  output logic               pdm_irsel_o,
  pdm_deserializer_if.master out_if
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(WIDTH);
  localparam int DW = CHANNELS * WIDTH;

  logic [CW-1:0]                  div_q, div_d;
  logic                           pclk_q, pclk_d;
  logic [BW-1:0]                  bit_q, bit_d;
  logic                           tick, complete, load;
  logic [CHANNELS-1:0]            samp;
  logic [CHANNELS-1:0][WIDTH-1:0] word;
  logic [DW-1:0]                  data_q, data_d;
  logic                           valid_q, valid_d;
  logic                           ovr_q, ovr_d;

  assign tick     = enable && (div_q == CW'(CLK_DIV - 1));
  assign complete = samp[0] && (bit_q == BW'(WIDTH - 1));

  // channel 0 samples on the falling toggle, channel 1 on the rising one
  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    assign samp[g] = tick && ((g == 0) ? pclk_q : !pclk_q);

    pdm_deserializer_chan #(.WIDTH(WIDTH)) u_chan (
      .clock      (clock),
      .reset      (reset),
      .clr        (!enable),
      .sample_i   (samp[g]),
      .bit_i      (data_in),
`ifdef PDM_DENSITY_EN
      .complete_i (complete),
`endif
      .field_o    (word[g])
    );
  end

  always_comb begin
    div_d  = '0;
    pclk_d = 1'b0;
    bit_d  = '0;
    if (enable) begin
      div_d  = tick ? '0 : div_q + CW'(1);
      pclk_d = pclk_q ^ tick;
      bit_d  = bit_q;
      if (samp[0]) bit_d = (bit_q == BW'(WIDTH - 1)) ? '0 : bit_q + BW'(1);
    end

    // a read in the completion cycle frees the buffer for the new word
    load    = complete && (!valid_q || out_if.ready_i);
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = word;
    end else if (valid_q && out_if.ready_i) begin
      valid_d = 1'b0;
    end
    ovr_d = complete && valid_q && !out_if.ready_i;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      div_q   <= '0;
      pclk_q  <= 1'b0;
      bit_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      div_q   <= div_d;
      pclk_q  <= pclk_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign pdm_clk_o        = pclk_q;
  assign pdm_irsel_o      = 1'b0;
  assign out_if.data_o    = data_q;
  assign out_if.valid_o   = valid_q;
  assign out_if.overrun_o = ovr_q;
endmodule

// File: tb/tb_pdm_deserializer.sv
// Bench for pdm_deserializer: mono and stereo instances checked every cycle against a queue model.
module tb_pdm_deserializer;
  localparam int CD = 2;
  localparam int W  = 8;
  localparam int WP = 2 * CD * W;

`ifdef PDM_DENSITY_EN
  localparam logic [15:0] E_ONES_M = 16'h0008;
  localparam logic [15:0] E_B1_M   = 16'h0004;
  localparam logic [15:0] E_B1_S   = 16'h0804;
  localparam logic [15:0] E_ST_M   = 16'h0000;
  localparam logic [15:0] E_ST_S   = 16'h0800;
`else
  localparam logic [15:0] E_ONES_M = 16'h00FF;
  localparam logic [15:0] E_B1_M   = 16'h00B1;
  localparam logic [15:0] E_B1_S   = 16'hFFB1;
  localparam logic [15:0] E_ST_M   = 16'h0000;
  localparam logic [15:0] E_ST_S   = 16'hFF00;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1, enable = 1'b0, data_in = 1'b0;
  logic pclk_m, pclk_s, irs_m, irs_s;
  int   errs = 0, checks = 0;

  always #5 clock = ~clock;

  pdm_deserializer_if #(.DW(W))     if_m ();
  pdm_deserializer_if #(.DW(2 * W)) if_s ();

  pdm_deserializer #(.CLK_DIV(CD), .WIDTH(W), .CHANNELS(1)) u_mono (
    .clock(clock), .reset(reset), .enable(enable), .data_in(data_in),
    .pdm_clk_o(pclk_m), .pdm_irsel_o(irs_m), .out_if(if_m.master));

  pdm_deserializer #(.CLK_DIV(CD), .WIDTH(W), .CHANNELS(2)) u_stereo (
    .clock(clock), .reset(reset), .enable(enable), .data_in(data_in),
    .pdm_clk_o(pclk_s), .pdm_irsel_o(irs_s), .out_if(if_s.master));

  // model: t counts cycles since enable; PDM events fall every CD cycles, alternating rise/fall
  int        t = 0;
  bit        q0[$];
  bit        q1[$];
  bit        e_pclk = 0;
  bit        e_valid[2] = '{0, 0};
  bit        e_ovr[2]   = '{0, 0};
  bit [15:0] e_data[2]  = '{0, 0};
  bit        seeded = 0;

  function automatic bit [7:0] field(input bit q[$]);
    bit [7:0] v = '0;
`ifdef PDM_DENSITY_EN
    foreach (q[i]) v = v + 8'(q[i]);
`else
    foreach (q[i]) v[W-1-i] = q[i];
`endif
    return v;
  endfunction

  task automatic model_step();
    bit        comp = 0;
    bit [15:0] word[2];
    bit        rdy[2];
    rdy[0] = if_m.ready_i;
    rdy[1] = if_s.ready_i;
    if (reset || !enable) begin
      t = 0;
      q0.delete();
      q1.delete();
      e_pclk = 0;
    end else begin
      if ((t + 1) % CD == 0) begin
        int e = (t + 1) / CD - 1;
        if (e % 2 == 0) q1.push_back(data_in);
        else begin
          q0.push_back(data_in);
          if (q0.size() == W) comp = 1;
        end
        e_pclk = 1'(((t + 1) / CD) % 2);
      end
      t++;
    end
    if (comp) begin
      word[0] = {8'h00, field(q0)};
      word[1] = {field(q1), field(q0)};
      q0.delete();
      q1.delete();
    end
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        e_valid[i] = 0; e_data[i] = '0; e_ovr[i] = 0;
      end else if (comp && (!e_valid[i] || rdy[i])) begin
        e_valid[i] = 1; e_data[i] = word[i]; e_ovr[i] = 0;
      end else if (comp) begin
        e_ovr[i] = 1;
      end else begin
        e_ovr[i] = 0;
        if (e_valid[i] && rdy[i]) e_valid[i] = 0;
      end
    end
    if (reset) seeded = 1;
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, got, want, $time);
    end
  endtask

  task automatic compare();
    if (!seeded) return;
    chk("pdm_clk_m", pclk_m, e_pclk);
    chk("pdm_clk_s", pclk_s, e_pclk);
    chk("irsel_m", irs_m, 0);
    chk("irsel_s", irs_s, 0);
    chk("valid_m", if_m.valid_o, e_valid[0]);
    chk("valid_s", if_s.valid_o, e_valid[1]);
    chk("data_m", if_m.data_o, e_data[0]);
    chk("data_s", if_s.data_o, e_data[1]);
    chk("ovr_m", if_m.overrun_o, e_ovr[0]);
    chk("ovr_s", if_s.overrun_o, e_ovr[1]);
  endtask

  task automatic tick();
    model_step();
    @(negedge clock);
    compare();
  endtask

  int        prise[$];
  int        vrise[$];
  bit [15:0] fdat[2];
  bit        fseen[2];
  int        novr[2];

  // dm: 0 all ones, 1 fall pattern B1 / rise 1, 2 rise 1 / fall 0, 3 ones then zeros, 4 zeros
  // rm: 0 ready high, 1 ready low, 2 ready only in the second completion cycle
  task automatic drive_run(input int n, input int dm, input int rm);
    bit [7:0] pat = 8'hB1;
    bit pp = 0, pv = 0;
    prise.delete(); vrise.delete();
    fseen = '{0, 0}; novr = '{0, 0};
    for (int c = 0; c < n; c++) begin
      enable  = 1;
      data_in = 1'($urandom);
      case (dm)
        0: data_in = 1;
        1: if (c % (2*CD) == 2*CD-1) data_in = pat[7 - (c / (2*CD)) % 8];
           else if (c % (2*CD) == CD-1) data_in = 1;
        2: if (c % (2*CD) == 2*CD-1) data_in = 0;
           else if (c % (2*CD) == CD-1) data_in = 1;
        3: data_in = (c < WP);
        default: data_in = 0;
      endcase
      case (rm)
        0: begin if_m.ready_i = 1; if_s.ready_i = 1; end
        1: begin if_m.ready_i = 0; if_s.ready_i = 0; end
        default: begin if_m.ready_i = (c == 2*WP-1); if_s.ready_i = (c == 2*WP-1); end
      endcase
      tick();
      if (pclk_m && !pp) prise.push_back(c);
      pp = pclk_m;
      if (if_m.valid_o && !pv) vrise.push_back(c);
      pv = if_m.valid_o;
      if (if_m.valid_o && !fseen[0]) begin fseen[0] = 1; fdat[0] = 16'(if_m.data_o); end
      if (if_s.valid_o && !fseen[1]) begin fseen[1] = 1; fdat[1] = if_s.data_o; end
      novr[0] += int'(if_m.overrun_o);
      novr[1] += int'(if_s.overrun_o);
    end
  endtask

  task automatic idle(input int n);
    enable = 0;
    for (int i = 0; i < n; i++) begin
      data_in = 1'($urandom);
      tick();
      chk("pclk_disabled", pclk_m, 0);
    end
  endtask

  initial begin
    if_m.ready_i = 0;
    if_s.ready_i = 0;
    for (int i = 0; i < 3; i++) tick();
    chk("rst_pclk", pclk_m, 0);
    chk("rst_valid", if_m.valid_o, 0);
    chk("rst_data", if_s.data_o, 0);
    chk("rst_ovr", if_m.overrun_o, 0);
    reset = 0;
    idle(2);

    // constant ones, mono timing and word
    drive_run(80, 0, 0);
    chk("pclk_first_rise", prise[0], CD - 1);
    chk("pclk_period", prise[1] - prise[0], 2 * CD);
    chk("first_valid", vrise[0], WP - 1);
    chk("word_period", vrise[1] - vrise[0], WP);
    chk("ones_word", fdat[0], E_ONES_M);
    idle(3);

    // bit order
    drive_run(40, 1, 0);
    chk("bitorder_m", fdat[0], E_B1_M);
    chk("bitorder_s", fdat[1], E_B1_S);
    idle(2);

    // stereo channel split
    drive_run(40, 2, 0);
    chk("stereo_m", fdat[0], E_ST_M);
    chk("stereo_s", fdat[1], E_ST_S);
    idle(2);

    // backpressure: two completions unread
    drive_run(70, 3, 1);
    chk("bp_ovr_count", novr[0], 1);
    chk("bp_held_valid", if_m.valid_o, 1);
    chk("bp_held_data", if_m.data_o, E_ONES_M);
    if_m.ready_i = 1; if_s.ready_i = 1;
    tick();
    chk("bp_drained", if_m.valid_o, 0);
    idle(2);

    // read coinciding with the next completion
    drive_run(2 * WP, 3, 2);
    chk("simul_valid", if_m.valid_o, 1);
    chk("simul_data", if_m.data_o, 0);
    chk("simul_no_ovr", novr[0] + novr[1], 0);
    if_m.ready_i = 1; if_s.ready_i = 1;
    idle(2);

    // enable dropped after three falls
    drive_run(3 * 2 * CD + 1, 0, 0);
    idle(5);
    drive_run(WP + 4, 4, 0);
    chk("reen_timing", vrise[0], WP - 1);
    chk("reen_data_m", fdat[0], 0);
    chk("reen_data_s", fdat[1], 0);

    // reset with a held word and a partial one
    drive_run(WP + 6, 0, 1);
    reset = 1;
    tick();
    reset = 0;
    chk("rstmid_pclk", pclk_m, 0);
    chk("rstmid_valid_m", if_m.valid_o, 0);
    chk("rstmid_data_m", if_m.data_o, 0);
    chk("rstmid_valid_s", if_s.valid_o, 0);
    chk("rstmid_data_s", if_s.data_o, 0);
    chk("rstmid_ovr", if_s.overrun_o, 0);

    // random traffic with bursts of backpressure
    for (int i = 0; i < 4000; i++) begin
      reset   = ($urandom_range(0, 999) == 0);
      enable  = ($urandom_range(0, 149) != 0);
      data_in = 1'($urandom);
      if ((i / 96) % 3 == 2) begin
        if_m.ready_i = 0; if_s.ready_i = 0;
      end else begin
        if_m.ready_i = ($urandom_range(0, 3) != 0);
        if_s.ready_i = ($urandom_range(0, 1) != 0);
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
